// File: rtl/link_credit_sched_pkg.sv
// Shared types and defaults for the link credit scheduler: FSM states,
// default credit/token sizing and the credit counter width helper.
package link_sched_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } sched_state_e;

  localparam int DEF_CREDITS   = 16;
  localparam int DEF_TOKEN_DIV = 4;

  // Counter must hold the full value CREDITS, not just CREDITS-1.
  function automatic int cred_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/link_credit_sched_if.sv
// Bundle of requester, channel, token and halt signals for link_credit_sched.
// The scheduler takes the slave view; the core/link side takes the master view.
interface link_credit_sched_if
  import link_sched_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_CH  = 2,
  parameter int DW      = 16,
  parameter int CW      = cred_width(DEF_CREDITS)
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic [NUM_CH-1:0]     ch_valid_o;
  logic [NUM_CH*DW-1:0]  ch_data_o;
  logic [NUM_CH-1:0]     token_i;
  logic                  halt_i;
  logic                  halt_ack_o;
  logic [NUM_CH*CW-1:0]  credit_o;
  logic                  err_o;

  modport master (
    output req_valid_i, req_data_i, token_i, halt_i,
    input  req_ready_o, ch_valid_o, ch_data_o, halt_ack_o, credit_o, err_o
  );

  modport slave (
    input  req_valid_i, req_data_i, token_i, halt_i,
    output req_ready_o, ch_valid_o, ch_data_o, halt_ack_o, credit_o, err_o
  );
endinterface

// File: rtl/link_credit_sched_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant to the first set request
// at or after ptr, wrapping modulo N. The pointer itself lives in the parent.
module rr_arb #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_credit_sched.sv
// Credit-throttled scheduler: arbitrates requesters onto link channels in
// strict round-robin striping order, with a halt/drain quiesce state machine.
module link_credit_sched
  import link_sched_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_CH    = 2,
  parameter int DW        = 16,
  parameter int CREDITS   = DEF_CREDITS,
  parameter int TOKEN_DIV = DEF_TOKEN_DIV
) (
  input logic               clk,
  input logic               rst,
  link_credit_sched_if.slave bus
);

  localparam int CW  = cred_width(CREDITS);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW  = CW + $clog2(TOKEN_DIV + 1) + 1;

  sched_state_e        state_q, state_d;
  logic [CHW-1:0]      ch_ptr_q, ch_ptr_d;
  logic [RW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]       credit_q [NUM_CH];
  logic [CW-1:0]       credit_d [NUM_CH];
  logic [NUM_CH-1:0]   token_q, token_d;
  logic [NUM_CH-1:0]   ch_valid_q, ch_valid_d;
  logic [DW-1:0]       ch_data_q [NUM_CH];
  logic [DW-1:0]       ch_data_d [NUM_CH];
  logic                err_q, err_d;

  logic                run_en;
  logic                halt_ack;
  logic                all_full;
  logic [NUM_REQ-1:0]  arb_req;
  logic [NUM_REQ-1:0]  grant;
  logic                xfer;
  logic [RW-1:0]       gnt_idx;
  logic [DW-1:0]       gnt_data;
  logic [NUM_CH-1:0]   ovf;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= INIT;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (bus.halt_i) state_d = DRAIN;
      DRAIN: begin
        if (!bus.halt_i)   state_d = RUN;
        else if (all_full) state_d = HALTED;
      end
      HALTED:  if (!bus.halt_i) state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run_en   = (state_q == RUN);
    halt_ack = (state_q == HALTED);
  end

  always_comb begin
    all_full = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (credit_q[c] != CW'(CREDITS)) all_full = 1'b0;
    end
  end

  // No skipping: an empty channel at ch_ptr blocks everyone to keep striping order.
  assign arb_req = (run_en && (credit_q[ch_ptr_q] != '0)) ? bus.req_valid_i : '0;

  rr_arb #(.N(NUM_REQ), .PW(RW)) u_arb (
    .req   (arb_req),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  assign xfer = |grant;

  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant[r]) begin
        gnt_idx  = RW'(r);
        gnt_data = bus.req_data_i[r*DW +: DW];
      end
    end
  end

  always_comb begin
    ch_ptr_d = ch_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      ch_ptr_d = (ch_ptr_q == CHW'(NUM_CH - 1)) ? '0 : ch_ptr_q + 1'b1;
      rr_ptr_d = (gnt_idx == RW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign token_d = bus.token_i;
  assign err_d   = err_q | (|ovf);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic          consume;
    logic          ret;
    logic [SW-1:0] sum;

    assign consume = xfer && (ch_ptr_q == CHW'(gi));
    assign ret     = bus.token_i[gi] ^ token_q[gi];
    // Consume and return in one cycle net to +TOKEN_DIV-1; overshoot clamps.
    assign sum     = SW'(credit_q[gi]) + (ret ? SW'(TOKEN_DIV) : SW'(0))
                   - (consume ? SW'(1) : SW'(0));
    assign ovf[gi] = (sum > SW'(CREDITS));
    assign credit_d[gi]   = ovf[gi] ? CW'(CREDITS) : sum[CW-1:0];
    assign ch_valid_d[gi] = consume;
    assign ch_data_d[gi]  = consume ? gnt_data : ch_data_q[gi];

    assign bus.credit_o[gi*CW +: CW]  = credit_q[gi];
    assign bus.ch_data_o[gi*DW +: DW] = ch_data_q[gi];
  end

  // Token copies track token_i even in reset so release never fakes a token.
  always_ff @(posedge clk) begin
    token_q <= token_d;
    if (rst) begin
      ch_ptr_q   <= '0;
      rr_ptr_q   <= '0;
      ch_valid_q <= '0;
      err_q      <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        credit_q[c]  <= CW'(CREDITS);
        ch_data_q[c] <= '0;
      end
    end else begin
      ch_ptr_q   <= ch_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      ch_valid_q <= ch_valid_d;
      err_q      <= err_d;
      for (int c = 0; c < NUM_CH; c++) begin
        credit_q[c]  <= credit_d[c];
        ch_data_q[c] <= ch_data_d[c];
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.ch_valid_o  = ch_valid_q;
  assign bus.halt_ack_o  = halt_ack;
  assign bus.err_o       = err_q;

endmodule

// File: tb/tb_link_credit_sched.sv
// Randomized and directed bench for link_credit_sched against a cycle-level
// behavioural model of the scheduling, credit and halt rules.
module tb_link_credit_sched;

  localparam int NUM_REQ   = 2;
  localparam int NUM_CH    = 2;
  localparam int DW        = 16;
  localparam int CREDITS   = 16;
  localparam int TOKEN_DIV = 4;
  localparam int CW        = $clog2(CREDITS + 1);

  localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;

  logic clk = 1'b0;
  logic rst;

  link_credit_sched_if #(.NUM_REQ(NUM_REQ), .NUM_CH(NUM_CH), .DW(DW), .CW(CW)) bus ();

  link_credit_sched #(
    .NUM_REQ(NUM_REQ), .NUM_CH(NUM_CH), .DW(DW),
    .CREDITS(CREDITS), .TOKEN_DIV(TOKEN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int                m_mode;
  int                m_cred [NUM_CH];
  int                m_chp;
  int                m_rr;
  logic              m_err;
  logic [NUM_CH-1:0] m_tok;
  logic [NUM_CH-1:0] m_sv;
  logic [DW-1:0]     m_sd [NUM_CH];

  logic [NUM_CH-1:0] tok_drv;
  logic [DW-1:0]     tdat [NUM_REQ];
  logic              halt_drv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] v);
    if (m_mode != M_RUN || m_cred[m_chp] == 0) return -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int r = (m_rr + k) % NUM_REQ;
      if (v[r]) return r;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_INIT;
    m_chp  = 0;
    m_rr   = 0;
    m_err  = 1'b0;
    m_sv   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cred[c] = CREDITS;
      m_sd[c]   = '0;
    end
  endtask

  // One clock: drive at negedge, check at negedge+1, then advance the model.
  task automatic step(input logic [NUM_REQ-1:0] v, input logic [NUM_CH-1:0] tog,
                      input logic h, input logic r, input bit chk);
    int                g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic [NUM_CH-1:0]  evt;
    bit                 full;
    @(negedge clk);
    tok_drv         = tok_drv ^ tog;
    bus.token_i     = tok_drv;
    bus.req_valid_i = v;
    for (int q = 0; q < NUM_REQ; q++) begin
      tdat[q] = DW'($urandom);
      bus.req_data_i[q*DW +: DW] = tdat[q];
    end
    bus.halt_i = h;
    rst        = r;
    #1;
    g       = pick(v);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (chk) begin
      check("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
      check("ch_valid", 64'(bus.ch_valid_o), 64'(m_sv));
      for (int c = 0; c < NUM_CH; c++) begin
        check($sformatf("ch_data%0d", c), 64'(bus.ch_data_o[c*DW +: DW]), 64'(m_sd[c]));
        check($sformatf("credit%0d", c), 64'(bus.credit_o[c*CW +: CW]), 64'(m_cred[c]));
      end
      check("err", 64'(bus.err_o), 64'(m_err));
      check("halt_ack", 64'(bus.halt_ack_o), 64'(m_mode == M_HALTED));
    end
    if (r) begin
      model_reset();
      m_tok = tok_drv;
    end else begin
      evt   = tok_drv ^ m_tok;
      m_tok = tok_drv;
      full  = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (m_cred[c] != CREDITS) full = 1'b0;
      case (m_mode)
        M_INIT:   m_mode = M_RUN;
        M_RUN:    if (h) m_mode = M_DRAIN;
        M_DRAIN:  m_mode = !h ? M_RUN : (full ? M_HALTED : M_DRAIN);
        default:  if (!h) m_mode = M_RUN;
      endcase
      m_sv = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        int nv = m_cred[c] + (evt[c] ? TOKEN_DIV : 0) - ((g >= 0 && c == m_chp) ? 1 : 0);
        if (nv > CREDITS) begin
          nv    = CREDITS;
          m_err = 1'b1;
        end
        m_cred[c] = nv;
      end
      if (g >= 0) begin
        $display("xfer r%0d -> ch%0d data %h", g, m_chp, tdat[g]);
        m_sv[m_chp]  = 1'b1;
        m_sd[m_chp]  = tdat[g];
        m_chp = (m_chp + 1) % NUM_CH;
        m_rr  = (g + 1) % NUM_REQ;
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    tok_drv         = '1;
    halt_drv        = 1'b0;
    bus.token_i     = tok_drv;
    bus.req_valid_i = '0;
    bus.req_data_i  = '0;
    bus.halt_i      = 1'b0;
    model_reset();
    m_tok = tok_drv;

    // reset release with token_i held high
    step('0, '0, 0, 1, 0);
    step('0, '0, 0, 1, 1);
    step('1, '0, 0, 0, 1);                     // INIT: no grant
    for (int i = 0; i < 8; i++) step('1, '0, 0, 0, 1);
    step('0, '0, 0, 0, 1);
    check("plan_cred12", 64'(bus.credit_o), 64'({5'd12, 5'd12}));

    // exhaust credits, then one ch0 token unblocks
    for (int i = 0; i < 26; i++) step('1, '0, 0, 0, 1);
    check("plan_stall", 64'(bus.req_ready_o), 64'(0));
    step('1, 2'b01, 0, 0, 1);
    step('1, '0, 0, 0, 1);
    step('0, '0, 0, 0, 1);

    // overflow clamp and sticky err
    step('0, '0, 0, 1, 1);
    step('0, '0, 0, 0, 1);
    step(2'b01, '0, 0, 0, 1);
    step('0, 2'b01, 0, 0, 1);
    for (int i = 0; i < 4; i++) step('1, '0, 0, 0, 1);
    check("plan_err_sticky", 64'(bus.err_o), 64'(1));

    // halt with four outstanding credits per channel
    step('0, '0, 0, 1, 1);
    step('0, '0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step('1, '0, 0, 0, 1);
    step('0, '0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step('1, '0, 1, 0, 1);
    step('1, 2'b11, 1, 0, 1);
    step('1, '0, 1, 0, 1);
    step('1, '0, 1, 0, 1);
    check("plan_halt_ack", 64'(bus.halt_ack_o), 64'(1));
    step('1, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step('1, '0, 0, 0, 1);

    // reset mid-stream with tokens toggling
    for (int i = 0; i < 4; i++) step('1, 2'(i), 0, 0, 1);
    step('1, 2'b11, 0, 1, 1);
    step('1, '0, 0, 0, 1);
    check("plan_rst_credit", 64'(bus.credit_o), 64'({5'd16, 5'd16}));
    for (int i = 0; i < 4; i++) step('1, '0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [NUM_CH-1:0] tg;
      logic              rr;
      if ($urandom_range(0, 19) == 0) halt_drv = ~halt_drv;
      tg = ($urandom_range(0, 5) == 0) ? NUM_CH'($urandom) : '0;
      rr = ($urandom_range(0, 149) == 0);
      step(NUM_REQ'($urandom), tg, halt_drv, rr, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
